// File: rtl/ascii_pkg.sv
// ASCII constants, FSM encoding and the BCD digit to ASCII helper for the digit sender.
package ascii_pkg;

  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_Q     = 8'h3F;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Nibbles 0..9 become '0'..'9'. Anything else becomes '?' so that corrupt
  // input still yields a printable, fixed-length frame.
  function automatic logic [7:0] bcd2asc(input logic [3:0] nib);
    return (nib <= 4'd9) ? (ASCII_0 + {4'h0, nib}) : ASCII_Q;
  endfunction

endpackage

// File: rtl/ascii_frame_rom.sv
// Combinational byte lookup: frame position plus snapshot word -> ASCII byte.
module ascii_frame_rom
  import ascii_pkg::*;
#(
  parameter int         ADD_CRLF = 1,
  parameter logic [7:0] SEP_HM   = ASCII_COLON,
  parameter logic [7:0] SEP_MS   = ASCII_COLON,
  parameter logic [7:0] SEP_SC   = ASCII_DOT
) (
  input  logic [3:0]  index,
  input  logic [31:0] snapshot,
  output logic [7:0]  char_out
);

  // Fixed "HH:MM:SS.CC[\r\n]" layout; positions past the frame read as 0.
  always_comb begin
    char_out = 8'h00;
    case (index)
      4'd0:  char_out = bcd2asc(snapshot[31:28]);
      4'd1:  char_out = bcd2asc(snapshot[27:24]);
      4'd2:  char_out = SEP_HM;
      4'd3:  char_out = bcd2asc(snapshot[23:20]);
      4'd4:  char_out = bcd2asc(snapshot[19:16]);
      4'd5:  char_out = SEP_MS;
      4'd6:  char_out = bcd2asc(snapshot[15:12]);
      4'd7:  char_out = bcd2asc(snapshot[11:8]);
      4'd8:  char_out = SEP_SC;
      4'd9:  char_out = bcd2asc(snapshot[7:4]);
      4'd10: char_out = bcd2asc(snapshot[3:0]);
      4'd11: char_out = (ADD_CRLF != 0) ? ASCII_CR : 8'h00;
      4'd12: char_out = (ADD_CRLF != 0) ? ASCII_LF : 8'h00;
      default: char_out = 8'h00;
    endcase
  end

endmodule

// File: rtl/ascii_digit_sender.sv
// Snapshots an 8-digit BCD time word and streams it as ASCII text over valid/ready.
module ascii_digit_sender
  import ascii_pkg::*;
#(
  parameter int         ADD_CRLF = 1,
  parameter logic [7:0] SEP_HM   = 8'h3A,
  parameter logic [7:0] SEP_MS   = 8'h3A,
  parameter logic [7:0] SEP_SC   = 8'h2E
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        send_start,
  input  logic [31:0] digit_data,
  input  logic        tx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  output logic        busy,
  output logic        done
);

  // Index of the final byte: 12 with CR/LF, 10 without.
  localparam logic [3:0] LAST = (ADD_CRLF != 0) ? 4'd12 : 4'd10;

  state_t      state, state_nx;
  logic [3:0]  idx, idx_nx;
  logic [31:0] snap, snap_nx;
  logic [7:0]  data_nx;
  logic        vld_nx, busy_nx, done_nx;
  logic [7:0]  rom_byte;

  // The ROM looks at the *next* index/snapshot so the byte is registered
  // together with the index advance, keeping tx_data a clean flop output.
  ascii_frame_rom #(
    .ADD_CRLF (ADD_CRLF),
    .SEP_HM   (SEP_HM),
    .SEP_MS   (SEP_MS),
    .SEP_SC   (SEP_SC)
  ) u_rom (
    .index    (idx_nx),
    .snapshot (snap_nx),
    .char_out (rom_byte)
  );

  // Next-state and next-output logic; everything holds unless a case says otherwise.
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    snap_nx  = snap;
    data_nx  = tx_data;
    vld_nx   = tx_valid;
    busy_nx  = busy;
    done_nx  = done;
    case (state)
      ST_IDLE: begin
        if (send_start) begin
          snap_nx  = digit_data;
          idx_nx   = 4'd0;
          busy_nx  = 1'b1;
          vld_nx   = 1'b1;
          data_nx  = rom_byte;
          state_nx = ST_SEND;
        end
      end
      ST_SEND: begin
        if (tx_valid && tx_ready) begin
          if (idx == LAST) begin
            vld_nx   = 1'b0;
            busy_nx  = 1'b0;
            done_nx  = 1'b1;
            state_nx = ST_DONE;
          end else begin
            idx_nx  = idx + 4'd1;
            data_nx = rom_byte;
          end
        end
      end
      ST_DONE: begin
        done_nx  = 1'b0;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // State, snapshot, index and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      idx      <= 4'd0;
      snap     <= 32'h0;
      tx_data  <= 8'h00;
      tx_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      state    <= state_nx;
      idx      <= idx_nx;
      snap     <= snap_nx;
      tx_data  <= data_nx;
      tx_valid <= vld_nx;
      busy     <= busy_nx;
      done     <= done_nx;
    end
  end

endmodule
